theta_stage: RTL and testbench
==============================

Name: theta_stage

Overview:
- Keccak-f[1600] theta step: XORs each lane with the parity of two neighbouring columns.
- Sits directly upstream of the rho rotation stage and feeds it a 1600-bit state in the same lane packing.
- Implemented as a 2-stage registered pipeline with valid/ready handshake on both sides, so the permutation datapath can be stalled by downstream consumers.

Parameters:
- LANE_W, 64, lane width in bits; only 64 is supported. Total state is 25*LANE_W.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- enable  input  1  global advance; 0 freezes both pipeline stages and forces in_ready=0
- in_valid  input  1  state_in holds a valid state
- in_ready  output  1  stage can accept state_in this cycle
- state_in  input  1600  lane i = x+5y at bits [i*64 +: 64], x,y in 0..4
- out_valid  output  1  state_out holds a valid theta result
- out_ready  input  1  downstream (rho) accepts state_out this cycle
- state_out  output  1600  theta result, same packing as state_in

Behaviour:
- Reset (rst=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, state_out=0, internal state/parity registers=0. in_ready evaluates combinationally after reset release.
- Handshake: a transfer occurs on a cycle with valid=1, ready=1 and enable=1. Once out_valid=1, state_out is held stable until accepted. out_valid never drops without acceptance, except on reset.
- Stage 1 (on input accept):
  - Register state_in into s1_state.
  - Compute and register C[x] = XOR over y of A[x,y], for x=0..4 (5x64 bits).
- Stage 2 (on s1 advance):
  - D[x] = C[(x+4) mod 5] ^ rol(C[(x+1) mod 5],1), where rol is a 64-bit rotate left with bit 63 wrapping to bit 0.
  - s2_state[x,y] = s1_state[x,y] ^ D[x]. s2_state drives state_out directly.
- Advance rules (all gated by enable=1):
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = enable && (!s1_valid || s2_adv).
  - When s2_valid && out_ready and !s1_valid, s2_valid clears.
- Latency and throughput:
  - 2 cycles from input accept to out_valid=1 with no backpressure.
  - One state per cycle sustained when out_ready=1.
- Full condition: both stages valid and out_ready=0 → in_ready=0; both stages hold their data.
- Simultaneous events: when the output is accepted and a new input arrives in the same cycle, both stages move and no bubble is inserted.
- Wrap-around: column index x-1 for x=0 uses C[4]; x+1 for x=4 uses C[0].
- enable=0: no register changes, in_ready=0, out_valid held at its current value. Data is never dropped.
- Reset mid-operation: all in-flight states are discarded and out_valid falls immediately (asynchronous).

Optional Feature:
- THETA_PARITY_OUT_EN defined: adds output port parity_out [319:0] = registered C[0..4] (C[x] at [x*64 +: 64]) of the state currently in stage 2. It is valid and held together with state_out, and resets to 0.
- Undefined: the port and its registers are absent. Behaviour is otherwise identical.

Test Plan:
- All-zero state_in, in_valid=1, out_ready=1, enable=1 → out_valid rises exactly 2 cycles after accept with state_out=0.
- Single bit: lane0=64'h1, rest 0 → lane0=64'h1; lanes 1,6,11,16,21=64'h1; lanes 4,9,14,19,24=64'h2; all other lanes 0.
- Parity cancellation: lane0=lane5=64'h8000_0000_0000_0001, rest 0 → state_out equals state_in.
- Backpressure: out_ready=0, stream states S0,S1,S2 → S0 and S1 accepted, in_ready=0 while S2 is offered; state_out=theta(S0) is held stable. Release out_ready → theta(S0), theta(S1), theta(S2) emerge in order on consecutive cycles.
- enable=0 for 3 cycles mid-stream with out_ready=1 → no transfers, outputs frozen. Resume → sequence continues with no loss or duplication.
- Assert rst=0 with both stages valid → out_valid=0 and state_out=0 immediately, without waiting for clk. After release, the first new input appears 2 cycles after accept.

Source files
------------

// File: rtl/theta_stage.sv
// Keccak-f[1600] theta step as a 2-stage valid/ready pipeline: stage 1 registers the state plus column parities, stage 2 applies D[x].
// Optional: define THETA_PARITY_OUT_EN to export the stage-2 column parities on parity_out.
module theta_stage #(
   parameter int LANE_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [25*LANE_W-1:0]  state_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [25*LANE_W-1:0]  state_out
`ifdef THETA_PARITY_OUT_EN
   ,
   output logic [5*LANE_W-1:0]   parity_out
`endif
);

   localparam int STATE_W = 25 * LANE_W;
   localparam int COL_W   = 5 * LANE_W;

   // C[x] = XOR of the five lanes in column x, packed at [x*LANE_W +: LANE_W].
   function automatic logic [COL_W-1:0] column_parity(input logic [STATE_W-1:0] a);
      logic [COL_W-1:0] c;
      c = '0;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            c[x*LANE_W +: LANE_W] ^= a[(x + 5*y)*LANE_W +: LANE_W];
         end
      end
      return c;
   endfunction

   function automatic logic [STATE_W-1:0] theta_apply(input logic [STATE_W-1:0] a,
                                                      input logic [COL_W-1:0]   c);
      logic [STATE_W-1:0] r;
      logic [LANE_W-1:0]  c_lo;
      logic [LANE_W-1:0]  c_hi;
      logic [LANE_W-1:0]  d;
      r = '0;
      for (int x = 0; x < 5; x++) begin
         c_lo = c[((x + 4) % 5)*LANE_W +: LANE_W];
         c_hi = c[((x + 1) % 5)*LANE_W +: LANE_W];
         d    = c_lo ^ {c_hi[LANE_W-2:0], c_hi[LANE_W-1]};
         for (int y = 0; y < 5; y++) begin
            r[(x + 5*y)*LANE_W +: LANE_W] = a[(x + 5*y)*LANE_W +: LANE_W] ^ d;
         end
      end
      return r;
   endfunction

   logic               s1_valid_q, s1_valid_d;
   logic [STATE_W-1:0] s1_state_q, s1_state_d;
   logic [COL_W-1:0]   c_q, c_d;
   logic               s2_valid_q, s2_valid_d;
   logic [STATE_W-1:0] s2_state_q, s2_state_d;
`ifdef THETA_PARITY_OUT_EN
   logic [COL_W-1:0]   par_q, par_d;
`endif

   logic s2_adv;
   logic s1_take;

   assign s2_adv   = enable && s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = enable && (!s1_valid_q || s2_adv);
   assign s1_take  = in_ready && in_valid;

   // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_state_d = s1_state_q;
      c_d        = c_q;
      s2_valid_d = s2_valid_q;
      s2_state_d = s2_state_q;
`ifdef THETA_PARITY_OUT_EN
      par_d      = par_q;
`endif
      if (s1_take) begin
         s1_valid_d = 1'b1;
         s1_state_d = state_in;
         c_d        = column_parity(state_in);
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         s2_valid_d = 1'b1;
         s2_state_d = theta_apply(s1_state_q, c_q);
`ifdef THETA_PARITY_OUT_EN
         par_d      = c_q;
`endif
      end else if (enable && s2_valid_q && out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   // NOTE: the wide datapath registers are reset too, because state_out and parity_out must read 0 while in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_state_q <= '0;
         c_q        <= '0;
         s2_valid_q <= 1'b0;
         s2_state_q <= '0;
`ifdef THETA_PARITY_OUT_EN
         par_q      <= '0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_state_q <= s1_state_d;
         c_q        <= c_d;
         s2_valid_q <= s2_valid_d;
         s2_state_q <= s2_state_d;
`ifdef THETA_PARITY_OUT_EN
         par_q      <= par_d;
`endif
      end
   end

   assign out_valid = s2_valid_q;
   assign state_out = s2_state_q;
`ifdef THETA_PARITY_OUT_EN
   assign parity_out = par_q;
`endif

endmodule

// File: tb/tb_theta_stage.sv
// Self-checking bench for theta_stage: directed cases plus randomized traffic against an occupancy/queue model.
module tb_theta_stage;

   localparam int W  = 64;
   localparam int SW = 25 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] state_in;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] state_out;
`ifdef THETA_PARITY_OUT_EN
   logic [5*W-1:0] parity_out;
`endif

   theta_stage #(.LANE_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out)
`ifdef THETA_PARITY_OUT_EN
      ,
      .parity_out(parity_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0]  data;
      logic [5*W-1:0] par;
      int             stage;
   } entry_t;

   entry_t        q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   logic          last_acc_in;
   logic          last_acc_out;
   logic [SW-1:0] last_out;

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      int lane;
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         lane = 0;
         for (int i = 24; i >= 0; i--) if (got[i*W +: W] !== exp[i*W +: W]) lane = i;
         $display("FAIL %s @%0t: lane %0d got %h expected %h", tag, $time, lane,
                  got[lane*W +: W], exp[lane*W +: W]);
      end
   endtask

   // Reference theta on a 5x5 lane array, straight from the column-parity definition.
   function automatic logic [SW-1:0] ref_theta(input logic [SW-1:0] s, output logic [5*W-1:0] cout);
      logic [W-1:0] a [5][5];
      logic [W-1:0] c [5];
      logic [W-1:0] d;
      logic [SW-1:0] r;
      for (int x = 0; x < 5; x++) begin
         c[x] = '0;
         for (int y = 0; y < 5; y++) begin
            a[x][y] = s[(x + 5*y)*W +: W];
            c[x] ^= a[x][y];
         end
         cout[x*W +: W] = c[x];
      end
      for (int x = 0; x < 5; x++) begin
         d = c[(x + 4) % 5] ^ ((c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> (W - 1)));
         for (int y = 0; y < 5; y++) r[(x + 5*y)*W +: W] = a[x][y] ^ d;
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] rand_state();
      logic [SW-1:0] s;
      for (int i = 0; i < SW/32; i++) s[i*32 +: 32] = $urandom;
      return s;
   endfunction

   // One clock cycle: inputs already driven; check outputs, then advance the model on the edge.
   task automatic step();
      logic   exp_ov, exp_ir, acc_in, acc_out;
      entry_t e;
      #1;
      exp_ov = (q.size() > 0) && (q[0].stage == 2);
      exp_ir = enable && ((q.size() < 2) || out_ready);
      check("in_ready", SW'(in_ready), SW'(exp_ir));
      check("out_valid", SW'(out_valid), SW'(exp_ov));
      if (exp_ov) begin
         check("state_out", state_out, q[0].data);
`ifdef THETA_PARITY_OUT_EN
         check("parity_out", SW'(parity_out), SW'(q[0].par));
`endif
      end
      acc_in       = exp_ir && in_valid;
      acc_out      = enable && exp_ov && out_ready;
      last_acc_in  = acc_in;
      last_acc_out = acc_out;
      if (acc_out) last_out = state_out;
      e.data  = ref_theta(state_in, e.par);
      e.stage = 1;
      @(posedge clk);
      if (enable) begin
         if (acc_out) void'(q.pop_front());
         if (q.size() > 0) q[0].stage = 2;
         if (acc_in) q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      enable    = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) step();
      step();
   endtask

   task automatic send_wait(input logic [SW-1:0] s, output logic [SW-1:0] got, output int lat);
      int n;
      got = '0;
      lat = -1;
      in_valid  = 1'b1;
      state_in  = s;
      out_ready = 1'b1;
      enable    = 1'b1;
      n = 0;
      do begin step(); n++; end while (!last_acc_in && n < 20);
      in_valid = 1'b0;
      if (!last_acc_in) begin
         check("accept_timeout", SW'(0), SW'(1));
         return;
      end
      n = 0;
      do begin step(); n++; end while (!last_acc_out && n < 20);
      if (!last_acc_out) begin
         check("output_timeout", SW'(0), SW'(1));
         return;
      end
      got = last_out;
      lat = n;
   endtask

   initial begin
      logic [SW-1:0] s, got, exp;
      logic [SW-1:0] bp [3];
      int lat;

      rst = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", SW'(out_valid), SW'(0));
      check("rst_state_out", state_out, '0);
`ifdef THETA_PARITY_OUT_EN
      check("rst_parity_out", SW'(parity_out), '0);
`endif
      rst = 1'b1;
      step();

      // All-zero state, latency 2
      send_wait('0, got, lat);
      check("zero_state", got, '0);
      check("zero_latency", SW'(lat), SW'(2));

      // Single bit in lane 0
      s = '0; s[0] = 1'b1;
      exp = '0;
      exp[0*W +: W] = 64'h1;
      for (int y = 0; y < 5; y++) begin
         exp[(1 + 5*y)*W +: W] = 64'h1;
         exp[(4 + 5*y)*W +: W] = 64'h2;
      end
      send_wait(s, got, lat);
      check("single_bit", got, exp);
      check("single_latency", SW'(lat), SW'(2));

      // Parity cancellation, including the bit-63 rotate wrap
      s = '0;
      s[0*W +: W] = 64'h8000_0000_0000_0001;
      s[5*W +: W] = 64'h8000_0000_0000_0001;
      send_wait(s, got, lat);
      check("parity_cancel", got, s);
      drain();

      // Backpressure: S0,S1 accepted, S2 stalled, then three back-to-back outputs
      for (int i = 0; i < 3; i++) bp[i] = rand_state();
      out_ready = 1'b0; in_valid = 1'b1;
      state_in = bp[0]; step();
      state_in = bp[1]; step();
      state_in = bp[2];
      repeat (4) step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (last_acc_in) in_valid = 1'b0;
      end
      drain();

      // enable=0 for 3 cycles mid-stream
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         enable   = !(i >= 4 && i < 7);
         state_in = rand_state();
         step();
      end
      drain();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         enable    = ($urandom_range(0, 7) != 0);
         state_in  = rand_state();
         step();
      end
      drain();

      // Asynchronous reset with both stages full
      out_ready = 1'b0; in_valid = 1'b1;
      state_in = rand_state(); step();
      state_in = rand_state(); step();
      in_valid = 1'b0;
      step();
      #2 rst = 1'b0;
      #1;
      check("async_rst_out_valid", SW'(out_valid), SW'(0));
      check("async_rst_state_out", state_out, '0);
      q.delete();
      @(negedge clk);
      rst = 1'b1;
      s = rand_state();
      send_wait(s, got, lat);
      check("post_rst_state", got, ref_theta(s, exp[5*W-1:0]));
      check("post_rst_latency", SW'(lat), SW'(2));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
